// File: rtl/tempsens_meas_scheduler_if.sv
// UART-side byte link of the temperature-sensor measurement scheduler:
// command bytes in from the receiver, result bytes out to the transmitter.
interface tempsens_meas_scheduler_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  // master: the UART side; slave: the scheduler
  modport master (output rx_ready, output rx_data, output tx_busy,
                  input tx_start, input tx_data);
  modport slave  (input rx_ready, input rx_data, input tx_busy,
                  output tx_start, output tx_data);
endinterface

// File: rtl/tempsens_meas_scheduler.sv
// Ring-oscillator temperature measurement scheduler: gates the oscillator, averages
// 2^LOG2_SAMPLES counter readings and ships the 16-bit result over the UART.
module tempsens_meas_scheduler #(
  parameter int         WIDTH        = 16,
  parameter int         GATE_CYCLES  = 1000,
  parameter int         LOG2_SAMPLES = 3,
  parameter logic [7:0] CMD_MEAS     = 8'h4D,
  parameter logic [7:0] CMD_CONT     = 8'h43,
  parameter logic [7:0] CMD_STOP     = 8'h53
) (
  input  logic                      clk,
  input  logic                      reset,
  tempsens_meas_scheduler_if.slave  uart,
  input  logic [WIDTH-1:0]          count,
  output logic                      osc_en,
  output logic                      cnt_clr,
  output logic [WIDTH-1:0]          result,
  output logic                      result_valid,
  output logic                      busy
);

  localparam int AW = WIDTH + LOG2_SAMPLES;
  localparam int IW = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, GATE, SETTLE, CAPTURE, AVG, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    acc_reg;
  logic [IW-1:0]    idx_reg;
  logic [GW-1:0]    gate_cnt_reg;
  logic [1:0]       wait_cnt_reg;
  logic             seen_busy_reg;
  logic             cont_reg;
  logic             osc_en_reg;
  logic             cnt_clr_reg;
  logic             tx_start_reg;
  logic [7:0]       tx_data_reg;
  logic [WIDTH-1:0] result_reg;
  logic             result_valid_reg;

  logic          cmd_meas, cmd_cont, cmd_stop, cont_eff, wait_done;
  logic [AW-1:0] acc_sum;

  assign cmd_meas = uart.rx_ready && (uart.rx_data == CMD_MEAS);
  assign cmd_cont = uart.rx_ready && (uart.rx_data == CMD_CONT);
  assign cmd_stop = uart.rx_ready && (uart.rx_data == CMD_STOP);
  // A STOP arriving in the last WAIT_HI cycle must already suppress the restart.
  assign cont_eff = cont_reg && !cmd_stop;
  assign acc_sum  = acc_reg + AW'(count);
  // Byte done once busy was seen high then low, or busy never rose within 2 cycles.
  assign wait_done = !uart.tx_busy && (seen_busy_reg || (wait_cnt_reg == 2'd2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      idx_reg          <= '0;
      gate_cnt_reg     <= '0;
      wait_cnt_reg     <= '0;
      seen_busy_reg    <= 1'b0;
      cont_reg         <= 1'b0;
      osc_en_reg       <= 1'b0;
      cnt_clr_reg      <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      cnt_clr_reg      <= 1'b0;
      tx_start_reg     <= 1'b0;
      result_valid_reg <= 1'b0;
      if (cmd_stop) cont_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_meas || cmd_cont) begin
            state_reg   <= CLEAR;
            acc_reg     <= '0;
            idx_reg     <= '0;
            cnt_clr_reg <= 1'b1;
            if (cmd_cont) cont_reg <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg    <= GATE;
          gate_cnt_reg <= '0;
          osc_en_reg   <= 1'b1;
        end
        GATE: begin
          if (gate_cnt_reg == GW'(GATE_CYCLES - 1)) begin
            state_reg    <= SETTLE;
            osc_en_reg   <= 1'b0;
            gate_cnt_reg <= '0;
          end else begin
            gate_cnt_reg <= gate_cnt_reg + 1'b1;
          end
        end
        SETTLE: begin
          if (gate_cnt_reg == GW'(1)) state_reg <= CAPTURE;
          else                        gate_cnt_reg <= gate_cnt_reg + 1'b1;
        end
        CAPTURE: begin
          acc_reg <= acc_sum;
          if (idx_reg == IDX_LAST) begin
            // result is loaded here so it is already valid during the AVG pulse
            state_reg        <= AVG;
            result_reg       <= WIDTH'(acc_sum >> LOG2_SAMPLES);
            result_valid_reg <= 1'b1;
          end else begin
            state_reg   <= CLEAR;
            idx_reg     <= idx_reg + 1'b1;
            cnt_clr_reg <= 1'b1;
          end
        end
        AVG: begin
          state_reg   <= SEND_LO;
          tx_data_reg <= result_reg[7:0];
        end
        SEND_LO, SEND_HI: begin
          if (!uart.tx_busy) begin
            state_reg     <= (state_reg == SEND_LO) ? WAIT_LO : WAIT_HI;
            tx_start_reg  <= 1'b1;
            seen_busy_reg <= 1'b0;
            wait_cnt_reg  <= '0;
          end
        end
        WAIT_LO, WAIT_HI: begin
          if (wait_done) begin
            if (state_reg == WAIT_LO) begin
              state_reg   <= SEND_HI;
              tx_data_reg <= result_reg[15:8];
            end else if (cont_eff) begin
              state_reg   <= CLEAR;
              acc_reg     <= '0;
              idx_reg     <= '0;
              cnt_clr_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            if (uart.tx_busy)          seen_busy_reg <= 1'b1;
            if (wait_cnt_reg != 2'd2)  wait_cnt_reg  <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign osc_en        = osc_en_reg;
  assign cnt_clr       = cnt_clr_reg;
  assign result        = result_reg;
  assign result_valid  = result_valid_reg;
  assign busy          = (state_reg != IDLE);
  assign uart.tx_start = tx_start_reg;
  assign uart.tx_data  = tx_data_reg;

endmodule

// File: tb/tb_tempsens_meas_scheduler.sv
// Directed bench for tempsens_meas_scheduler: counter and UART models driven on the
// falling edge, one task per scenario with hand-computed expected values.
module tb_tempsens_meas_scheduler;
  localparam int G = 10;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] count = 16'h0000;
  logic        osc_en, cnt_clr, result_valid, busy;
  logic [15:0] result;

  always #5 clk = ~clk;

  tempsens_meas_scheduler_if u_if ();

  tempsens_meas_scheduler #(
    .WIDTH(16), .GATE_CYCLES(G), .LOG2_SAMPLES(L),
    .CMD_MEAS(8'h4D), .CMD_CONT(8'h43), .CMD_STOP(8'h53)
  ) dut (
    .clk(clk), .reset(reset), .uart(u_if.slave), .count(count),
    .osc_en(osc_en), .cnt_clr(cnt_clr), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] cnt_vals [0:7];
  int          cnt_base = 0;
  int          clr_total = 0;
  int          valid_total = 0;
  int          start_total = 0;
  int          glitch_total = 0;
  int          busy_cnt = 0;
  int          run_len = 0;
  logic [7:0]  txd_hold = 8'h00;
  logic        hold_busy = 1'b0;
  int          osc_runs [$];
  logic [7:0]  tx_bytes [$];

  assign u_if.tx_busy = (busy_cnt != 0) || hold_busy;

  // Counter, UART and activity monitors
  always @(negedge clk) begin
    if (cnt_clr) begin
      count     <= cnt_vals[3'(clr_total - cnt_base)];
      clr_total <= clr_total + 1;
    end
    if (osc_en) run_len <= run_len + 1;
    else if (run_len != 0) begin
      osc_runs.push_back(run_len);
      run_len <= 0;
    end
    if (result_valid) valid_total <= valid_total + 1;
    if (u_if.tx_start) begin
      tx_bytes.push_back(u_if.tx_data);
      start_total <= start_total + 1;
      busy_cnt    <= 4;
      txd_hold    <= u_if.tx_data;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (u_if.tx_data !== txd_hold) glitch_total <= glitch_total + 1;
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    u_if.rx_data  = b;
    u_if.rx_ready = 1'b1;
    @(negedge clk);
    u_if.rx_ready = 1'b0;
  endtask

  task automatic set_vals(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: cnt_vals[i] = a;
        1: cnt_vals[i] = b;
        2: cnt_vals[i] = c;
        default: cnt_vals[i] = d;
      endcase
    end
    cnt_base = clr_total;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({osc_en, cnt_clr, u_if.tx_start, result_valid, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got osc_en/cnt_clr/tx_start/valid/busy=%b required 00000",
               {osc_en, cnt_clr, u_if.tx_start, result_valid, busy});
    end
    checks++;
    if (u_if.tx_data !== 8'h00 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got tx_data=%h result=%h required 00 0000", u_if.tx_data, result);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({osc_en, cnt_clr, u_if.tx_start, result_valid, busy} !== 5'b0 ||
          u_if.tx_data !== 8'h00 || result !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_quiet got %0d active cycles required 0", bad);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    int c0 = clr_total, v0 = valid_total, b0 = tx_bytes.size(), r0 = osc_runs.size();
    int n = 1, bad = 0;
    set_vals(16'd100, 16'd102, 16'd104, 16'd106);
    send_cmd(8'h4D);
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 57) begin
      failures++;
      $display("FAIL single_latency got %0d cycles required 57", n);
    end
    checks++;
    if (result !== 16'd103) begin
      failures++;
      $display("FAIL single_result got %0d required 103", result);
    end
    wait_idle("single");
    checks++;
    if (clr_total - c0 != 4 || valid_total - v0 != 1) begin
      failures++;
      $display("FAIL single_pulses got clr=%0d valid=%0d required 4 1", clr_total - c0, valid_total - v0);
    end
    for (int i = r0; i < osc_runs.size(); i++) if (osc_runs[i] != G) bad++;
    checks++;
    if (osc_runs.size() - r0 != 4 || bad != 0) begin
      failures++;
      $display("FAIL single_gate got windows=%0d bad_len=%0d required 4 0", osc_runs.size() - r0, bad);
    end
    checks++;
    if (tx_bytes.size() != b0 + 2 || tx_bytes[b0] !== 8'h67 || tx_bytes[b0+1] !== 8'h00) begin
      failures++;
      $display("FAIL single_bytes got count=%0d required 2 bytes 67 00", tx_bytes.size() - b0);
    end
    $display("test_single done result=%0d checks=%0d failures=%0d", result, checks, failures);
  endtask

  task automatic test_full_scale();
    int v0 = valid_total, b0 = tx_bytes.size();
    set_vals(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_cmd(8'h4D);
    wait_idle("full");
    checks++;
    if (result !== 16'hFFFF || valid_total - v0 != 1) begin
      failures++;
      $display("FAIL full_result got %h valid=%0d required ffff 1", result, valid_total - v0);
    end
    checks++;
    if (tx_bytes.size() != b0 + 2 || tx_bytes[b0] !== 8'hFF || tx_bytes[b0+1] !== 8'hFF) begin
      failures++;
      $display("FAIL full_bytes got count=%0d required 2 bytes ff ff", tx_bytes.size() - b0);
    end
    $display("test_full_scale done result=%h checks=%0d failures=%0d", result, checks, failures);
  endtask

  task automatic test_cont_stop();
    int c0 = clr_total, v0 = valid_total, b0 = tx_bytes.size(), n = 0;
    set_vals(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send_cmd(8'h43);
    while (!(clr_total - c0 >= 5 && osc_en === 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL cont_second_gate got timeout clr=%0d required 5 clears then gate", clr_total - c0);
    end
    send_cmd(8'h53);
    wait_idle("cont");
    checks++;
    if (valid_total - v0 != 2 || result !== 16'h1234) begin
      failures++;
      $display("FAIL cont_results got valid=%0d result=%h required 2 1234", valid_total - v0, result);
    end
    checks++;
    if (tx_bytes.size() != b0 + 4 || tx_bytes[b0] !== 8'h34 || tx_bytes[b0+1] !== 8'h12 ||
        tx_bytes[b0+2] !== 8'h34 || tx_bytes[b0+3] !== 8'h12) begin
      failures++;
      $display("FAIL cont_bytes got count=%0d required 4 bytes 34 12 34 12", tx_bytes.size() - b0);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (clr_total - c0 != 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_stopped got clr=%0d busy=%b required 8 0", clr_total - c0, busy);
    end
    $display("test_cont_stop done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    int c0 = clr_total, v0 = valid_total, b0 = tx_bytes.size(), s0 = start_total;
    int g0 = glitch_total, n = 0, bad = 0;
    set_vals(16'h1357, 16'h1357, 16'h1357, 16'h1357);
    send_cmd(8'h4D);
    while (result_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL bp_valid got timeout required result_valid");
    end
    hold_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      u_if.rx_ready = (i == 10) || (i == 25);
      u_if.rx_data  = (i == 25) ? 8'h43 : 8'h41;
      if (u_if.tx_start !== 1'b0 || u_if.tx_data !== 8'h57) bad++;
    end
    u_if.rx_ready = 1'b0;
    checks++;
    if (bad != 0 || start_total != s0) begin
      failures++;
      $display("FAIL bp_hold got bad_cycles=%0d starts=%0d required 0 0", bad, start_total - s0);
    end
    hold_busy = 1'b0;
    wait_idle("bp");
    checks++;
    if (start_total - s0 != 2 || glitch_total != g0) begin
      failures++;
      $display("FAIL bp_starts got starts=%0d glitches=%0d required 2 0", start_total - s0, glitch_total - g0);
    end
    checks++;
    if (tx_bytes.size() != b0 + 2 || tx_bytes[b0] !== 8'h57 || tx_bytes[b0+1] !== 8'h13) begin
      failures++;
      $display("FAIL bp_bytes got count=%0d required 2 bytes 57 13", tx_bytes.size() - b0);
    end
    repeat (80) @(negedge clk);
    checks++;
    if (clr_total - c0 != 4 || valid_total - v0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_ignored got clr=%0d valid=%0d busy=%b required 4 1 0",
               clr_total - c0, valid_total - v0, busy);
    end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_reset();
    int c0 = clr_total, n = 0, v0, b0;
    set_vals(16'd200, 16'd200, 16'd200, 16'd200);
    send_cmd(8'h4D);
    while (!(clr_total - c0 >= 2 && osc_en === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (osc_en !== 1'b1) begin
      failures++;
      $display("FAIL arst_gate got osc_en=%b required 1 before reset", osc_en);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (osc_en !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL arst_immediate got osc_en=%b busy=%b result=%h required 0 0 0000", osc_en, busy, result);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    c0 = clr_total;
    v0 = valid_total;
    b0 = tx_bytes.size();
    set_vals(16'd300, 16'd310, 16'd320, 16'd330);
    send_cmd(8'h4D);
    wait_idle("arst");
    checks++;
    if (result !== 16'd315 || valid_total - v0 != 1 || clr_total - c0 != 4) begin
      failures++;
      $display("FAIL arst_fresh got result=%0d valid=%0d clr=%0d required 315 1 4",
               result, valid_total - v0, clr_total - c0);
    end
    checks++;
    if (tx_bytes.size() != b0 + 2 || tx_bytes[b0] !== 8'h3B || tx_bytes[b0+1] !== 8'h01) begin
      failures++;
      $display("FAIL arst_bytes got count=%0d required 2 bytes 3b 01", tx_bytes.size() - b0);
    end
    $display("test_async_reset done result=%0d checks=%0d failures=%0d", result, checks, failures);
  endtask

  initial begin
    u_if.rx_ready = 1'b0;
    u_if.rx_data  = 8'h00;
    test_reset();
    test_single();
    test_full_scale();
    test_cont_stop();
    test_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tempsens_meas_scheduler.md
Name: tempsens_meas_scheduler

Overview:
Measurement scheduler for the ring-oscillator temperature sensor. It sequences the oscillator enable, counter clear and gate window, and accumulates 2^LOG2_SAMPLES counter readings into an average. It then sends the 16-bit result as two bytes through the UART transmitter. Commands arrive as bytes from the UART receiver. The block replaces ad-hoc enable/sum sequencing between the counter, averager and UART.

Parameters:
WIDTH, 16, counter and result width (must be 16 for the two-byte send)
GATE_CYCLES, 1000, clk cycles osc_en stays high per sample window (>=1)
LOG2_SAMPLES, 3, log2 of samples averaged per measurement (0..8)
CMD_MEAS, 8'h4D, single-measurement command ('M')
CMD_CONT, 8'h43, continuous-measurement command ('C')
CMD_STOP, 8'h53, stop-continuous command ('S')

Ports:
clk  input  1  system clock, single domain
reset  input  1  asynchronous, active-low reset
rx_ready  input  1  one-cycle pulse, rx_data valid
rx_data  input  8  received command byte
count  input  WIDTH  ring-oscillator counter value
osc_en  output  1  oscillator and counter enable
cnt_clr  output  1  one-cycle counter clear pulse
tx_start  output  1  one-cycle UART transmit request
tx_data  output  8  byte to transmit
tx_busy  input  1  UART transmitter busy
result  output  WIDTH  last averaged result
result_valid  output  1  one-cycle pulse when result updates
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; accumulator, sample index, gate counter and cont flag cleared. osc_en falls immediately, without waiting for a clk edge.
- States: IDLE, CLEAR, GATE, SETTLE, CAPTURE, AVG, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- IDLE:
  - rx_ready with CMD_MEAS: go to CLEAR; clear accumulator and sample index.
  - rx_ready with CMD_CONT: same as CMD_MEAS, and also set the cont flag.
  - Other bytes: ignored.
- CLEAR: cnt_clr=1 for exactly one cycle, osc_en=0. Next state GATE.
- GATE: osc_en=1 for exactly GATE_CYCLES consecutive cycles. Next state SETTLE.
- SETTLE: osc_en=0 for 2 cycles so the counter value is stable in the clk domain. Next state CAPTURE.
- CAPTURE: acc <= acc + zero-extended count.
  - acc width is WIDTH+LOG2_SAMPLES, so it never overflows.
  - If sample index == 2^LOG2_SAMPLES-1, go to AVG; otherwise increment the index and go to CLEAR.
- AVG: result <= acc >> LOG2_SAMPLES (truncating); result_valid=1 for one cycle. Next state SEND_LO.
- Per-sample latency: GATE_CYCLES+4 cycles. The result_valid pulse is 2^LOG2_SAMPLES*(GATE_CYCLES+4)+1 cycles after the command cycle.
- SEND_LO:
  - Drive tx_data=result[7:0].
  - Wait while tx_busy=1.
  - In the first cycle with tx_busy=0, assert tx_start for one cycle, then go to WAIT_LO.
- WAIT_LO:
  - Hold tx_data.
  - Wait until tx_busy has been seen high and then low; then go to SEND_HI.
  - tx_busy must rise within 2 cycles of tx_start. If it does not, treat the byte as sent after 2 cycles.
- SEND_HI / WAIT_HI: identical, using result[15:8]. On exit:
  - cont flag set: go to CLEAR with a fresh accumulator and sample index.
  - cont flag clear: go to IDLE.
- tx_start never asserts twice per byte. tx_data is stable from the SEND_x entry to the WAIT_x exit.
- CMD_STOP in any state clears the cont flag. The current measurement and its transmission complete, then the block returns to IDLE. CMD_STOP in IDLE has no effect.
- CMD_MEAS or CMD_CONT while busy: ignored (the cont flag is not set).
- If rx_ready coincides with the last cycle of WAIT_HI, the byte is evaluated in that cycle's state (STOP honoured; MEAS/CONT ignored).
- result holds its value until the next AVG; it is not cleared by commands.

Test Plan:
- Bench uses GATE_CYCLES=10, LOG2_SAMPLES=2 throughout.
- Reset: hold reset=0 -> all outputs 0, busy=0. Release and apply no command -> outputs stay 0 for 100 cycles.
- Single measurement: send 'M'; the count model returns 100, 102, 104, 106 per window.
  - cnt_clr pulses 4 times; osc_en is high exactly 10 cycles per window.
  - result=103 (0x0067) with one result_valid pulse.
  - tx bytes 0x67 then 0x00; busy falls afterwards.
- Full scale: count=0xFFFF for all samples -> result=0xFFFF, bytes FF FF, no wrap.
- Continuous/stop: send 'C' with constant count 0x1234.
  - Send 'S' during the second measurement's GATE.
  - Exactly two result_valid pulses; bytes 34 12 34 12; then IDLE.
- UART backpressure: hold tx_busy=1 for 50 cycles at SEND_LO.
  - tx_start stays low, then pulses exactly once after release.
  - tx_data stays stable through WAIT_LO.
  - Byte 0x41 sent during busy is ignored.
- Async reset mid-GATE: osc_en drops in the same timestep as reset falls. After release, 'M' restarts at sample 0 and result equals a fresh average.
